// File: rtl/drop_sequencer_pkg.sv
// Shared definitions for the drop sequencer: FSM state encoding, counter width
// and the command set of the shared cycle counter.
package drop_sequencer_pkg;

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitData = 2'd1,
    StArmed    = 2'd2,
    StCooldown = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CntHold = 2'd0,
    CntLoad = 2'd1,
    CntInc  = 2'd2,
    CntDec  = 2'd3
  } cnt_op_e;

endpackage

// File: rtl/drop_sequencer_cycle_counter.sv
// Loadable up/down counter shared by the WAIT_DATA, ARMED and COOLDOWN states.
//   clk, rst_n   : clock, asynchronous active-low reset (count clears to 0)
//   op_i         : hold / load / increment / decrement
//   load_val_i   : value taken on a load
//   count_o      : current count
//   zero_o       : count_o == 0
module drop_sequencer_cycle_counter
  import drop_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  cnt_op_e         op_i,
  input  logic [CntW-1:0] load_val_i,
  output logic [CntW-1:0] count_o,
  output logic            zero_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case (op_i)
      CntHold: count_d = count_q;
      CntLoad: count_d = load_val_i;
      CntInc:  count_d = count_q + 1'b1;
      CntDec:  count_d = count_q - 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/drop_sequencer.sv
// Sequencing controller for the baggage-drop display/drop stage.
// A request waits for a valid temperature sample, latches it, holds drop_en for
// DROP_CYCLES, then cools down for COOL_CYCLES. One request arriving during the
// window or cooldown is buffered and serviced next.
//   clk, rst_n        : clock, asynchronous active-low reset
//   drop_req          : drop request
//   t_valid           : t_act/t_lim valid this cycle
//   t_act, t_lim      : measured temperature and limit
//   drop_en           : enable to the display/drop decoder
//   t_act_q, t_lim_q  : latched sample for the decoder
//   busy              : FSM not in IDLE
//   done, result_hot  : window-finished pulse and its t_act_q > t_lim_q result
//   fault             : pulse on data timeout
module drop_sequencer
  import drop_sequencer_pkg::*;
#(
  parameter int unsigned DROP_CYCLES  = 8,
  parameter int unsigned COOL_CYCLES  = 4,
  parameter int unsigned DATA_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        drop_req,
  input  logic        t_valid,
  input  logic [15:0] t_act,
  input  logic [15:0] t_lim,
  output logic        drop_en,
  output logic [15:0] t_act_q,
  output logic [15:0] t_lim_q,
  output logic        busy,
  output logic        done,
  output logic        result_hot,
  output logic        fault
);

  localparam logic [CntW-1:0] DropLoad    = CntW'(DROP_CYCLES - 1);
  localparam logic [CntW-1:0] CoolLoad    = CntW'(COOL_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(DATA_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic            drop_en_q, drop_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            result_hot_q, result_hot_d;
  logic            fault_q, fault_d;
  logic [15:0]     t_act_d, t_lim_d;
  logic [15:0]     t_act_r, t_lim_r;
  logic            capture;
  cnt_op_e         cnt_op;
  logic [CntW-1:0] cnt_load;
  logic [CntW-1:0] cnt;
  logic            cnt_zero;

  drop_sequencer_cycle_counter u_cycle_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_i       (cnt_op),
    .load_val_i (cnt_load),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_op    = CntHold;
    cnt_load  = '0;
    capture   = 1'b0;
    fault_d   = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (drop_req || pending_q) begin
          state_d   = StWaitData;
          pending_d = 1'b0;
          cnt_op    = CntLoad;
          cnt_load  = '0;
        end
      end
      StWaitData: begin
        // t_valid on the last waiting cycle still wins over the timeout.
        if (t_valid) begin
          capture  = 1'b1;
          state_d  = StArmed;
          cnt_op   = CntLoad;
          cnt_load = DropLoad;
        end else if (cnt == TimeoutLast) begin
          state_d = StIdle;
          fault_d = 1'b1;
        end else begin
          cnt_op = CntInc;
        end
      end
      StArmed: begin
        pending_d = pending_q | drop_req;
        if (cnt_zero) begin
          state_d  = StCooldown;
          cnt_op   = CntLoad;
          cnt_load = CoolLoad;
          done_d   = 1'b1;
        end else begin
          cnt_op = CntDec;
        end
      end
      StCooldown: begin
        pending_d = pending_q | drop_req;
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_op = CntDec;
        end
      end
    endcase

    // Sample is already latched by the time the window closes.
    result_hot_d = done_d & (t_act_r > t_lim_r);
    drop_en_d    = (state_d == StArmed);
    busy_d       = (state_d != StIdle);
    t_act_d      = capture ? t_act : t_act_r;
    t_lim_d      = capture ? t_lim : t_lim_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pending_q    <= 1'b0;
      drop_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_hot_q <= 1'b0;
      fault_q      <= 1'b0;
      t_act_r      <= '0;
      t_lim_r      <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      drop_en_q    <= drop_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_hot_q <= result_hot_d;
      fault_q      <= fault_d;
      t_act_r      <= t_act_d;
      t_lim_r      <= t_lim_d;
    end
  end

  assign drop_en    = drop_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result_hot = result_hot_q;
  assign fault      = fault_q;
  assign t_act_q    = t_act_r;
  assign t_lim_q    = t_lim_r;

endmodule

// File: tb/tb_drop_sequencer.sv
// Scoreboard bench for drop_sequencer: stimulus pushes the expected done/fault
// event for each drop, a negedge monitor pops and compares when one appears.
module tb_drop_sequencer;

  logic        clk;
  logic        rst_n;
  logic        drop_req;
  logic        t_valid;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        drop_en;
  logic [15:0] t_act_q;
  logic [15:0] t_lim_q;
  logic        busy;
  logic        done;
  logic        result_hot;
  logic        fault;

  drop_sequencer #(
    .DROP_CYCLES  (8),
    .COOL_CYCLES  (4),
    .DATA_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drop_req   (drop_req),
    .t_valid    (t_valid),
    .t_act      (t_act),
    .t_lim      (t_lim),
    .drop_en    (drop_en),
    .t_act_q    (t_act_q),
    .t_lim_q    (t_lim_q),
    .busy       (busy),
    .done       (done),
    .result_hot (result_hot),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_fault;
    logic        hot;
    logic [15:0] act;
    logic [15:0] lim;
    int          cyc;
    int          drop_first;
    int          drop_len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  int   base     = 0;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc_cnt - base < c) tick();
  endtask

  function automatic exp_t mk(input logic f, input logic h, input logic [15:0] a,
                              input logic [15:0] l, input int c, input int df,
                              input int dl);
    exp_t e;
    e.is_fault = f; e.hot = h; e.act = a; e.lim = l;
    e.cyc = c; e.drop_first = df; e.drop_len = dl;
    return e;
  endfunction

  // Monitor: tracks the drop_en window and checks every done/fault event.
  int   rel;
  int   de_len   = 0;
  int   de_first = -1;
  exp_t e_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      de_len   = 0;
      de_first = -1;
    end else begin
      rel = cyc_cnt - base;
      if (drop_en) begin
        if (de_len == 0) de_first = rel;
        de_len++;
      end
      if (done || fault) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got done=%0b fault=%0b at cycle %0d, expected none",
                   done, fault, rel);
        end else begin
          e_m = exp_q.pop_front();
          chk("event_is_fault", int'(fault), int'(e_m.is_fault));
          chk("event_is_done", int'(done), int'(!e_m.is_fault));
          chk("event_cycle", rel, e_m.cyc);
          chk("t_act_q", int'(t_act_q), int'(e_m.act));
          chk("t_lim_q", int'(t_lim_q), int'(e_m.lim));
          chk("drop_en_len", de_len, e_m.drop_len);
          if (e_m.drop_len > 0) chk("drop_en_first", de_first, e_m.drop_first);
          if (!e_m.is_fault) chk("result_hot", int'(result_hot), int'(e_m.hot));
        end
        de_len   = 0;
        de_first = -1;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_drop_en"}, int'(drop_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_result_hot"}, int'(result_hot), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_t_act_q"}, int'(t_act_q), 0);
    chk({tag, "_t_lim_q"}, int'(t_lim_q), 0);
  endtask

  // Single drop with a sample in cycle 1; done in 10, IDLE again in 14.
  task automatic run_drop(input logic [15:0] a, input logic [15:0] l, input logic hot);
    base = cyc_cnt;
    drop_req = 1'b1;
    exp_q.push_back(mk(1'b0, hot, a, l, 10, 2, 8));
    tick();
    drop_req = 1'b0;
    t_valid  = 1'b1;
    t_act    = a;
    t_lim    = l;
    tick();
    t_valid = 1'b0;
    t_act   = 16'hDEAD;
    t_lim   = 16'hBEEF;
    wait_to(13);
    chk("drop_busy_c13", int'(busy), 1);
    wait_to(14);
    chk("drop_busy_c14", int'(busy), 0);
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    drop_req = 1'b0;
    t_valid  = 1'b0;
    t_act    = '0;
    t_lim    = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Cold, hot and equal-at-max samples.
    run_drop(16'd20, 16'd35, 1'b0);
    run_drop(16'd50, 16'd35, 1'b1);
    run_drop(16'hFFFF, 16'hFFFF, 1'b0);

    // Timeout: no t_valid; fault in cycle 17, latched sample unchanged.
    base = cyc_cnt;
    drop_req = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 17, 0, 0));
    tick();
    drop_req = 1'b0;
    wait_to(16);
    chk("timeout_busy_c16", int'(busy), 1);
    wait_to(17);
    chk("timeout_busy_c17", int'(busy), 0);
    tick();
    tick();

    // t_valid on the last waiting cycle (16) wins over the timeout.
    base = cyc_cnt;
    drop_req = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 16'd7, 16'd3, 25, 17, 8));
    tick();
    drop_req = 1'b0;
    wait_to(16);
    t_valid = 1'b1;
    t_act   = 16'd7;
    t_lim   = 16'd3;
    tick();
    t_valid = 1'b0;
    wait_to(28);
    chk("late_valid_busy_c28", int'(busy), 1);
    wait_to(29);
    chk("late_valid_busy_c29", int'(busy), 0);
    tick();

    // Pending: extra requests in cycles 5 and 12; only one extra drop runs.
    base = cyc_cnt;
    drop_req = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 16'd20, 16'd35, 10, 2, 8));
    exp_q.push_back(mk(1'b0, 1'b1, 16'd100, 16'd99, 25, 17, 8));
    tick();
    drop_req = 1'b0;
    t_valid  = 1'b1;
    t_act    = 16'd20;
    t_lim    = 16'd35;
    tick();
    t_valid = 1'b0;
    wait_to(5);
    drop_req = 1'b1;
    tick();
    drop_req = 1'b0;
    wait_to(12);
    drop_req = 1'b1;
    tick();
    drop_req = 1'b0;
    wait_to(14);
    chk("pending_idle_c14", int'(busy), 0);
    wait_to(15);
    chk("pending_wait_c15", int'(busy), 1);
    wait_to(16);
    t_valid = 1'b1;
    t_act   = 16'd100;
    t_lim   = 16'd99;
    tick();
    t_valid = 1'b0;
    wait_to(29);
    chk("pending_idle_c29", int'(busy), 0);
    wait_to(33);
    chk("third_req_lost_c33", int'(busy), 0);

    // Reset mid-window with a pending request.
    base = cyc_cnt;
    drop_req = 1'b1;
    tick();
    drop_req = 1'b0;
    t_valid  = 1'b1;
    t_act    = 16'd300;
    t_lim    = 16'd200;
    tick();
    t_valid = 1'b0;
    wait_to(3);
    drop_req = 1'b1;
    tick();
    drop_req = 1'b0;
    wait_to(6);
    chk("rst_pre_drop_en", int'(drop_en), 1);
    chk("rst_pre_t_act_q", int'(t_act_q), 300);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_drop_en", int'(drop_en), 0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
